// File: rtl/burst_memory_pkg.sv
// Shared opcodes, FSM state type and command helpers for the burst memory.
package burst_memory_pkg;

    localparam int unsigned OP_WIDTH = 2;

    localparam logic [OP_WIDTH-1:0] OP_READ  = 2'd1;
    localparam logic [OP_WIDTH-1:0] OP_WRITE = 2'd2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE      = 2'd1,
        READ_FETCH = 2'd2,
        READ_HOLD  = 2'd3
    } state_t;

    // Opcodes 0 and 3 are reserved and flagged as errors.
    function automatic logic op_is_legal(input logic [OP_WIDTH-1:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/burst_memory_ram.sv
// Synchronous single-port RAM, one-cycle read latency; array is never reset.
module burst_memory_ram #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register only updates on a fetch, so it holds the last word otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/burst_memory.sv
// Burst read/write front-end over a single-port RAM.
// Optional BURST_MEMORY_ZERO_IDLE_EN: force rd_data to zero while rd_valid is low.
module burst_memory
    import burst_memory_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [OP_WIDTH-1:0]   cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  cmd_err
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  err_d;
    logic                  ram_we;
    logic                  ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  last_word;

    assign last_word = (rem_q == '0);

    // Next-state, counter and RAM-strobe logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        err_d   = 1'b0;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d = cmd_addr;
                    rem_d  = cmd_len;
                    if (!op_is_legal(cmd_op)) begin
                        err_d = 1'b1;
                    end else if (cmd_op == OP_WRITE) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ_FETCH;
                    end
                end
            end
            WRITE: begin
                if (wr_valid && wr_ready) begin
                    ram_we = 1'b1;
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (last_word) begin
                        state_d = IDLE;
                    end else begin
                        rem_d = rem_q - LEN_WIDTH'(1);
                    end
                end
            end
            READ_FETCH: begin
                ram_re  = 1'b1;
                state_d = READ_HOLD;
            end
            READ_HOLD: begin
                if (rd_ready) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (last_word) begin
                        state_d = IDLE;
                    end else begin
                        rem_d   = rem_q - LEN_WIDTH'(1);
                        state_d = READ_FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and all handshake outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            cmd_ready <= (state_d == IDLE);
            busy      <= (state_d != IDLE);
            wr_ready  <= (state_d == WRITE);
            rd_valid  <= (state_d == READ_HOLD);
            cmd_err   <= err_d;
        end
    end

    burst_memory_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (ram_we),
        .re   (ram_re),
        .addr (addr_q),
        .wdata(wr_data),
        .rdata(ram_rdata)
    );

`ifdef BURST_MEMORY_ZERO_IDLE_EN
    assign rd_data = rd_valid ? ram_rdata : '0;
`else
    assign rd_data = ram_rdata;
`endif

endmodule

// File: doc/burst_memory.md
BURST_MEMORY -- requirements
Module: burst_memory

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, address bits; depth = 2**ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, burst length field width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports cmd_valid  input  1, cmd_ready  output  1  command handshake.
REQ-007 SHALL have port cmd_op  input  2  opcode: 1 = OP_READ, 2 = OP_WRITE; 0 and 3 illegal.
REQ-008 SHALL have ports cmd_addr  input  ADDR_WIDTH  start address, and cmd_len  input  LEN_WIDTH  word count minus one.
REQ-009 SHALL have ports wr_valid  input  1, wr_ready  output  1, wr_data  input  DATA_WIDTH  write stream.
REQ-010 SHALL have ports rd_valid  output  1, rd_ready  input  1, rd_data  output  DATA_WIDTH  read stream.
REQ-011 SHALL have port busy  output  1  high while a burst is in progress.
REQ-012 SHALL have port cmd_err  output  1  one-cycle pulse on an illegal opcode.

Function
REQ-013 SHALL implement FSM states IDLE, WRITE, READ_FETCH, READ_HOLD.
REQ-014 cmd_ready SHALL be high only in IDLE; a command is accepted on a cycle with cmd_valid and cmd_ready both high.
REQ-015 On accept, SHALL latch cmd_addr into an address counter and cmd_len into a remaining counter.
REQ-016 On accept with OP_WRITE, SHALL go to WRITE; with OP_READ, to READ_FETCH; with an illegal opcode, SHALL stay in IDLE and pulse cmd_err the next cycle.
REQ-017 In WRITE, wr_ready SHALL be high; each wr_valid and wr_ready cycle SHALL store wr_data at the current address, then increment the address.
REQ-018 In READ_FETCH, SHALL issue a synchronous RAM read of the current address and go to READ_HOLD the next cycle.
REQ-019 In READ_HOLD, rd_valid SHALL be high and rd_data SHALL hold the fetched word stable until rd_ready is high.
REQ-020 On the rd_valid and rd_ready cycle, SHALL increment the address and return to READ_FETCH, or to IDLE if it was the last word. Throughput is one word per 2 cycles.
REQ-021 A burst SHALL transfer exactly cmd_len+1 words; the word with remaining = 0 ends the burst, and the FSM SHALL be in IDLE the following cycle.
REQ-022 The address counter SHALL wrap modulo 2**ADDR_WIDTH (e.g. 8'hFF -> 8'h00).
REQ-023 busy SHALL be high in every state except IDLE.
REQ-024 wr_ready SHALL be low outside WRITE; rd_valid SHALL be low outside READ_HOLD.
REQ-025 Stalls (wr_valid low, rd_ready low) SHALL hold all state indefinitely, with no timeout.
REQ-026 Command inputs arriving while busy SHALL be ignored (cmd_ready is low).

Reset
REQ-027 Asserting rst_n low SHALL immediately force: state IDLE, cmd_ready 1, busy 0, wr_ready 0, rd_valid 0, rd_data 0, cmd_err 0, and both counters 0.
REQ-028 Reset SHALL abort any burst in progress without completing it; RAM contents SHALL NOT be cleared; words already written SHALL persist.

Configuration
REQ-029 Macro BURST_MEMORY_ZERO_IDLE_EN, when defined: rd_data SHALL be 0 on every cycle that rd_valid is 0.
REQ-030 Without BURST_MEMORY_ZERO_IDLE_EN: rd_data SHALL retain the last fetched word while rd_valid is 0.

Structure
REQ-031 Package burst_memory_pkg SHALL hold the opcode constants OP_READ = 2'd1 and OP_WRITE = 2'd2, and the FSM state typedef.
REQ-032 Storage SHALL be sub-module burst_memory_ram: a parametrised synchronous single-port RAM with 1-cycle read latency and no reset on the array.

Verification
REQ-033 Write, addr 8'h10, len 3, data A1 A2 A3 A4 -> wr_ready high 4 handshakes, then IDLE; read same range -> rd_data A1..A4 in order.
REQ-034 Write at addr 8'hFE, len 2, data 11 22 33 -> stored at FE, FF, 00; read at 8'h00, len 0 -> 33.
REQ-035 Read len 1 with rd_ready held low for 5 cycles -> rd_valid stays high and rd_data stable; then 2 words delivered; busy drops the cycle after the last handshake.
REQ-036 cmd_op = 3 with cmd_valid -> cmd_err pulses once, busy stays 0, and no RAM access occurs.
REQ-037 rst_n low after 2 of 4 write words -> IDLE; a re-read shows the 2 written words intact, the other 2 locations unchanged, and no outputs glitch high.
REQ-038 Run REQ-035 with and without BURST_MEMORY_ZERO_IDLE_EN -> rd_data is 0 versus the held last word while rd_valid is low.
